// File: rtl/uart_receiver_parity.sv
// UART receiver, 8 data bits + one parity bit (even/odd by parameter) + one stop bit.
// Latency: rxd start edge to result pulse = 2 + CLKS_PER_BIT/2 + 10*CLKS_PER_BIT + 1 clk.
// Backpressure: none; results are one-cycle pulses that must be captured when they appear.
//
// Ports:
//   clk        - single clock, all state on posedge
//   rst        - synchronous active-high reset
//   rxd        - serial line, idle high, asynchronous to clk
//   dout       - last received byte (loaded on every completed frame, held otherwise)
//   dout_valid - one-cycle pulse: frame completed without errors
//   parity_err - one-cycle pulse: frame completed with a parity mismatch
//   frame_err  - one-cycle pulse: stop bit sampled low
//   busy       - high whenever a frame is being received (state not IDLE)

module uart_receiver_parity #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic             sync_meta;
  logic             line;
  logic             line_q;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             par_mis;

  logic             half_tick;
  logic             bit_tick;
  logic             start_edge;
  logic             exp_par;

  logic             data_smp;
  logic             par_smp;
  logic             stop_smp;
  logic             data_arm;
  logic             cnt_clr;

  assign half_tick = (cnt == CNT_HALF);
  assign bit_tick  = (cnt == CNT_FULL);

  // Edge rather than level: after a framing error the line may still be low,
  // and we must see it go high before a new start bit is accepted.
  assign start_edge = line_q & ~line;

  assign exp_par = (^shreg) ^ ODD;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start_edge) state_nxt = S_START;
      end
      S_START: begin
        // Mid start bit: a high line here means the falling edge was a glitch.
        if (half_tick) state_nxt = line ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (bit_tick && (bit_idx == 3'd7)) state_nxt = S_PARITY;
      end
      S_PARITY: begin
        if (bit_tick) state_nxt = S_STOP;
      end
      S_STOP: begin
        // Leave at mid stop bit so a start bit right after it is not missed.
        if (bit_tick) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    busy     = 1'b0;
    data_smp = 1'b0;
    par_smp  = 1'b0;
    stop_smp = 1'b0;
    data_arm = 1'b0;
    cnt_clr  = 1'b0;
    unique case (state)
      S_IDLE: begin
        cnt_clr = 1'b1;
      end
      S_START: begin
        busy     = 1'b1;
        data_arm = half_tick;
        cnt_clr  = half_tick;
      end
      S_DATA: begin
        busy     = 1'b1;
        data_smp = bit_tick;
        cnt_clr  = bit_tick;
      end
      S_PARITY: begin
        busy    = 1'b1;
        par_smp = bit_tick;
        cnt_clr = bit_tick;
      end
      S_STOP: begin
        busy     = 1'b1;
        stop_smp = bit_tick;
        cnt_clr  = bit_tick;
      end
      default: begin
        cnt_clr = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: synchronizer, bit counter, shift register, result pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta  <= 1'b1;
      line       <= 1'b1;
      line_q     <= 1'b1;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shreg      <= 8'h00;
      par_mis    <= 1'b0;
      dout       <= 8'h00;
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync_meta <= rxd;
      line      <= sync_meta;
      line_q    <= line;

      cnt <= cnt_clr ? '0 : cnt + 1'b1;

      if (data_arm) begin
        bit_idx <= 3'd0;
      end else if (data_smp) begin
        bit_idx <= bit_idx + 3'd1;
        // LSB arrives first, so shift in from the top.
        shreg   <= {line, shreg[7:1]};
      end

      // Mismatch is held until the stop bit decides which pulse to raise.
      if (par_smp) begin
        par_mis <= line ^ exp_par;
      end

      if (stop_smp) begin
        dout <= shreg;
      end
      dout_valid <= stop_smp & line & ~par_mis;
      parity_err <= stop_smp & par_mis;
      frame_err  <= stop_smp & ~line;
    end
  end

endmodule

// File: tb/tb_uart_receiver_parity.sv
// Directed bench for uart_receiver_parity: even-parity and odd-parity instances,
// hand-computed frames, pulse counters sampled on the falling clock edge.

module tb_uart_receiver_parity;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       odd_sel;
  logic       rxd_e;
  logic       rxd_o;

  logic [7:0] dout_e, dout_o;
  logic       dout_valid_e, parity_err_e, frame_err_e, busy_e;
  logic       dout_valid_o, parity_err_o, frame_err_o, busy_o;

  always #5 clk = ~clk;

  // Only the selected instance sees traffic; the other sits on an idle line.
  assign rxd_e = odd_sel ? 1'b1 : rxd;
  assign rxd_o = odd_sel ? rxd : 1'b1;

  uart_receiver_parity #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut_e (
    .clk(clk), .rst(rst), .rxd(rxd_e), .dout(dout_e),
    .dout_valid(dout_valid_e), .parity_err(parity_err_e),
    .frame_err(frame_err_e), .busy(busy_e)
  );

  uart_receiver_parity #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1)) dut_o (
    .clk(clk), .rst(rst), .rxd(rxd_o), .dout(dout_o),
    .dout_valid(dout_valid_o), .parity_err(parity_err_o),
    .frame_err(frame_err_o), .busy(busy_o)
  );

  // Cycle counter and pulse monitors
  int         cyc = 0;
  int         n_val_e = 0, n_perr_e = 0, n_ferr_e = 0;
  int         n_val_o = 0, n_perr_o = 0, n_ferr_o = 0;
  int         val_cyc = 0;
  logic [7:0] cap [0:7];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dout_valid_e) begin
      cap[n_val_e % 8] <= dout_e;
      val_cyc          <= cyc;
      n_val_e          <= n_val_e + 1;
    end
    if (parity_err_e) n_perr_e <= n_perr_e + 1;
    if (frame_err_e)  n_ferr_e <= n_ferr_e + 1;
    if (dout_valid_o) n_val_o  <= n_val_o + 1;
    if (parity_err_o) n_perr_o <= n_perr_o + 1;
    if (frame_err_o)  n_ferr_o <= n_ferr_o + 1;
  end

  int n_chk  = 0;
  int n_pass = 0;
  int b_val, b_perr, b_ferr;
  int bo_val, bo_perr, bo_ferr;
  int t0, lat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic snap();
    b_val   = n_val_e;  b_perr  = n_perr_e; b_ferr  = n_ferr_e;
    bo_val  = n_val_o;  bo_perr = n_perr_o; bo_ferr = n_ferr_o;
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask

  task automatic idle_bits(input int n);
    rxd = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  initial begin
    rst     = 1'b1;
    rxd     = 1'b1;
    odd_sel = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_dout", 32'(dout_e), 32'h00);
    chk("rst_flags_busy", 32'({dout_valid_e, parity_err_e, frame_err_e, busy_e}), 32'h0);
    chk("rst_odd_flags_busy", 32'({dout_valid_o, parity_err_o, frame_err_o, busy_o}), 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 0xA5, correct even parity 0, good stop; also latency from start edge
    snap();
    t0 = cyc;
    send_frame(8'hA5, 1'b0, 1'b1);
    idle_bits(1);
    lat = val_cyc - t0;
    chk("a5_valid_cnt", 32'(n_val_e - b_val), 32'd1);
    chk("a5_dout", 32'(cap[b_val % 8]), 32'hA5);
    chk("a5_err_cnt", 32'((n_perr_e - b_perr) + (n_ferr_e - b_ferr)), 32'd0);
    chk("a5_latency_171pm1", 32'((lat >= 170) && (lat <= 172)), 32'd1);
    chk("a5_idle_busy", 32'(busy_e), 32'd0);

    // 0x01 with wrong parity bit 0 (needs 1)
    snap();
    send_frame(8'h01, 1'b0, 1'b1);
    idle_bits(1);
    chk("perr_cnt", 32'(n_perr_e - b_perr), 32'd1);
    chk("perr_no_valid", 32'(n_val_e - b_val), 32'd0);
    chk("perr_no_ferr", 32'(n_ferr_e - b_ferr), 32'd0);
    chk("perr_dout", 32'(dout_e), 32'h01);

    // 6-cycle low glitch while idle
    snap();
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    chk("glitch_busy_hi", 32'(busy_e), 32'd1);
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch_busy_lo", 32'(busy_e), 32'd0);
    chk("glitch_no_pulse",
        32'((n_val_e - b_val) + (n_perr_e - b_perr) + (n_ferr_e - b_ferr)), 32'd0);
    chk("glitch_dout_held", 32'(dout_e), 32'h01);

    // Back-to-back 0xFF then 0x00, no idle gap
    snap();
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h00, 1'b0, 1'b1);
    idle_bits(1);
    chk("b2b_valid_cnt", 32'(n_val_e - b_val), 32'd2);
    chk("b2b_first", 32'(cap[b_val % 8]), 32'hFF);
    chk("b2b_second", 32'(cap[(b_val + 1) % 8]), 32'h00);
    chk("b2b_err_cnt", 32'((n_perr_e - b_perr) + (n_ferr_e - b_ferr)), 32'd0);

    // 0x3C with low stop bit, line kept low afterwards: no re-arm
    snap();
    send_frame(8'h3C, 1'b0, 1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    chk("ferr_cnt", 32'(n_ferr_e - b_ferr), 32'd1);
    chk("ferr_no_valid", 32'(n_val_e - b_val), 32'd0);
    chk("ferr_no_perr", 32'(n_perr_e - b_perr), 32'd0);
    chk("ferr_dout", 32'(dout_e), 32'h3C);
    chk("ferr_low_no_rearm", 32'(busy_e), 32'd0);
    idle_bits(2);
    snap();
    send_frame(8'h55, 1'b0, 1'b1);
    idle_bits(1);
    chk("after_ferr_valid", 32'(n_val_e - b_val), 32'd1);
    chk("after_ferr_dout", 32'(cap[b_val % 8]), 32'h55);

    // Reset in the middle of data bit 4 of 0x5A
    snap();
    send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    rxd = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_dout", 32'(dout_e), 32'h00);
    chk("abort_flags_busy", 32'({dout_valid_e, parity_err_e, frame_err_e, busy_e}), 32'h0);
    idle_bits(12);
    chk("abort_no_pulse",
        32'((n_val_e - b_val) + (n_perr_e - b_perr) + (n_ferr_e - b_ferr)), 32'd0);
    snap();
    send_frame(8'hC3, 1'b0, 1'b1);
    idle_bits(1);
    chk("c3_even_valid", 32'(n_val_e - b_val), 32'd1);
    chk("c3_even_dout", 32'(dout_e), 32'hC3);

    // Odd-parity instance: 0xC3 needs parity bit 1
    odd_sel = 1'b1;
    @(negedge clk);
    snap();
    send_frame(8'hC3, 1'b1, 1'b1);
    idle_bits(1);
    chk("c3_odd_valid", 32'(n_val_o - bo_val), 32'd1);
    chk("c3_odd_no_err", 32'((n_perr_o - bo_perr) + (n_ferr_o - bo_ferr)), 32'd0);
    chk("c3_odd_dout", 32'(dout_o), 32'hC3);
    snap();
    send_frame(8'hC3, 1'b0, 1'b1);
    idle_bits(1);
    chk("c3_odd_bad_perr", 32'(n_perr_o - bo_perr), 32'd1);
    chk("c3_odd_bad_no_valid", 32'(n_val_o - bo_val), 32'd0);
    chk("even_quiet", 32'(n_val_e - b_val), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_receiver_parity.md
UART_RECEIVER_PARITY -- requirements
Module: uart_receiver_parity

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit period (legal range 4..65535).
REQ-002 SHALL have parameter PARITY_ODD, default 0, meaning 0 = even parity (parity bit = ^data), 1 = odd parity (parity bit = ~^data).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rxd  input  1  serial line; idle high; asynchronous to clk.
REQ-006 SHALL have port dout  output  8  last received data byte.
REQ-007 SHALL have port dout_valid  output  1  one-cycle pulse when a frame completes with no errors.
REQ-008 SHALL have port parity_err  output  1  one-cycle pulse when a frame completes with a parity mismatch.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-010 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 SHALL pass rxd through a 2-flop synchronizer; all references to "line" below mean the synchronized value (2-cycle added latency).
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-013 IDLE: SHALL wait for line = 0, then go to START with the bit-period counter cleared.
REQ-014 START: SHALL resample at counter = CLKS_PER_BIT/2 - 1 (floor); line = 0 -> DATA with counter cleared; line = 1 -> IDLE (glitch rejected, no flags).
REQ-015 DATA: SHALL sample the line each time the counter reaches CLKS_PER_BIT - 1 (mid-bit), then clear the counter.
REQ-015a DATA: SHALL shift sampled bits into the shift register LSB first; after the 8th sample SHALL go to PARITY.
REQ-016 PARITY: SHALL sample one bit at mid-bit and compare it with the parity of the 8 data bits per PARITY_ODD; the mismatch result SHALL be held until STOP completes.
REQ-017 STOP: SHALL sample at mid-bit and then return to IDLE, with the output action set by the sampled stop bit and held mismatch:
  - stop = 1, no mismatch -> dout_valid
  - stop = 1, mismatch -> parity_err
  - stop = 0 -> frame_err, plus parity_err if mismatch.
REQ-018 SHALL pulse dout_valid, parity_err and frame_err for exactly one clk, in the cycle after the stop-bit sample.
REQ-019 SHALL load dout with the shift register on every completed frame (including errored frames); dout SHALL hold its value otherwise.
REQ-020 SHALL return from STOP to IDLE after the stop-bit sample (mid stop bit), so a start bit immediately following the stop bit is detected.
REQ-021 SHALL size the bit-period counter as clog2(CLKS_PER_BIT) bits; the counter SHALL never wrap without a state action.
REQ-022 On a framing error, SHALL NOT re-arm on the low stop level: return to IDLE, which requires line = 1 for at least one cycle before detecting a new start bit.
REQ-023 SHALL exhibit latency from the rxd start edge to the output pulse of 2 + CLKS_PER_BIT/2 + 10*CLKS_PER_BIT + 1 clk (+/-1).

Reset
REQ-024 While rst = 1 at posedge clk: state = IDLE, counter = 0, shift register = 0, dout = 8'h00, dout_valid = parity_err = frame_err = busy = 0, synchronizer flops = 1.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no output pulse; reception SHALL resume at the next falling edge after rst deasserts.

Verification (CLKS_PER_BIT = 16, PARITY_ODD = 0 unless stated)
REQ-026 Send 0xA5, parity 0, stop 1 -> one dout_valid pulse, dout = 8'hA5, no error flags.
REQ-027 Send 0x01 with parity bit 0 (wrong; expected 1) -> parity_err pulse, dout = 8'h01, no dout_valid.
REQ-028 Send 0x3C with stop bit 0 -> frame_err pulse, no dout_valid; line then held high; then send 0x55 -> dout_valid with dout = 8'h55.
REQ-029 6-cycle low glitch on rxd in IDLE -> returns to IDLE, busy falls within 10 cycles, no pulses.
REQ-030 Back-to-back frames 0xFF then 0x00 with no idle gap -> two dout_valid pulses, values 8'hFF then 8'h00.
REQ-031 rst pulsed during the DATA bit 4 of 0x5A -> no pulse, all outputs 0; next frame 0xC3 -> dout = 8'hC3; with PARITY_ODD = 1, 0xC3 needs parity bit 1.
